// File: rtl/branch_target_loader.sv
// Byte-stream loader for the branch-target table: pairs of bytes become D-bit
// targets written into N entries, with a combinational index-to-target read port.
module branch_target_loader #(
    parameter int D = 10,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic [3:0]   rd_addr,
    output logic [D-1:0] rd_target,
    output logic         busy,
    output logic         done,
    output logic         fmt_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // High-byte bits above target[D-1] must be zero; none exist when D == 16.
    localparam logic [7:0] HI_MASK = (D < 16) ? 8'(8'hFF << (D - 8)) : 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lo_hold_q, lo_hold_d;
    logic            fmt_err_q, fmt_err_d;
    logic            done_q, done_d;
    logic            wr_en;
    logic            accept;
    logic [D-1:0]    wr_data;
    logic [D-1:0]    rd_vec [16];

    assign in_ready = (state_q != IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign wr_data  = {in_data[D-9:0], lo_hold_q};
    assign done     = done_q;
    assign fmt_err  = fmt_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_hold_d = lo_hold_q;
        fmt_err_d = fmt_err_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_LO;
                    cnt_d     = '0;
                    fmt_err_d = 1'b0;
                end
            end
            LOAD_LO: begin
                if (start) begin
                    cnt_d     = '0;
                    fmt_err_d = 1'b0;
                end else if (accept) begin
                    lo_hold_d = in_data;
                    state_d   = LOAD_HI;
                end
            end
            LOAD_HI: begin
                // A restart wins over a byte presented in the same cycle.
                if (start) begin
                    state_d   = LOAD_LO;
                    cnt_d     = '0;
                    fmt_err_d = 1'b0;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if ((in_data & HI_MASK) != 8'h00) begin
                        fmt_err_d = 1'b1;
                    end
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = LOAD_LO;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lo_hold_q <= 8'h00;
            fmt_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lo_hold_q <= lo_hold_d;
            fmt_err_q <= fmt_err_d;
            done_q    <= done_d;
        end
    end

    // Entries are flops rather than RAM: reset must clear every target at once.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : gen_tbl
            if (gi < N) begin : gen_entry
                logic [D-1:0] entry_q, entry_d;

                always_comb begin
                    entry_d = entry_q;
                    if (wr_en && (cnt_q == CW'(gi))) begin
                        entry_d = wr_data;
                    end
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        entry_q <= '0;
                    end else begin
                        entry_q <= entry_d;
                    end
                end

                assign rd_vec[gi] = entry_q;
            end else begin : gen_pad
                assign rd_vec[gi] = '0;
            end
        end
    endgenerate

    assign rd_target = rd_vec[rd_addr];

endmodule

// File: tb/tb_branch_target_loader.sv
// Directed test of branch_target_loader: reset, full load, stall, format error,
// restart priority and mid-load reset, all with hand-computed expectations.
module tb_branch_target_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  rd_addr;
    logic [9:0]  rd_target;
    logic        busy;
    logic        done;
    logic        fmt_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    branch_target_loader #(.D(10), .N(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_target (rd_target),
        .busy      (busy),
        .done      (done),
        .fmt_err   (fmt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        rd_addr = 4'(addr);
        #1;
        chk(tag, 32'(rd_target), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_entry(input logic [15:0] t);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    int tgt [16] = '{0, 10, 45, 103, 76, 91, 84, 101, 1, 18, 0, 300, 512, 1023, 777, 256};
    int d0;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = 4'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fmt_err", 32'(fmt_err), 0);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("rst_rd%0d", i), i, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 16-entry load
        pulse_start();
        chk("load_busy", 32'(busy), 1);
        chk("load_in_ready", 32'(in_ready), 1);
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) load_entry(16'(tgt[i]));
        send_byte(8'(tgt[15] & 255));
        chk("load_done_early", 32'(done), 0);
        send_byte(8'(tgt[15] >> 8));
        chk("load_done_pulse", 32'(done), 1);
        chk("load_busy_end", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("load_done_drop", 32'(done), 0);
        chk("load_done_count", 32'(done_cnt - d0), 1);
        rd_chk("load_rd3", 3, 103);
        rd_chk("load_rd9", 9, 18);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("load_rd%0d", i), i, tgt[i]);
        chk("load_fmt_err", 32'(fmt_err), 0);

        // Stall between low and high byte of entry 2
        pulse_start();
        load_entry(16'd5);
        load_entry(16'd6);
        send_byte(8'hFF);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy), 1);
        chk("stall_in_ready", 32'(in_ready), 1);
        rd_chk("stall_rd2_old", 2, 45);
        send_byte(8'h03);
        rd_chk("stall_rd2_new", 2, 1023);
        d0 = done_cnt;
        for (int i = 3; i < 16; i++) load_entry(16'(i * 3));
        chk("stall_done", 32'(done), 1);
        rd_chk("stall_rd2", 2, 1023);
        rd_chk("stall_rd1", 1, 6);
        rd_chk("stall_rd15", 15, 45);

        // Nonzero unused high-byte bits
        pulse_start();
        load_entry(16'hFC05);
        chk("fmt_err_set", 32'(fmt_err), 1);
        rd_chk("fmt_rd0", 0, 5);
        for (int i = 1; i < 16; i++) load_entry(16'(200 + i));
        chk("fmt_done", 32'(done), 1);
        chk("fmt_err_hold", 32'(fmt_err), 1);
        pulse_start();
        chk("fmt_err_clear", 32'(fmt_err), 0);

        // Restart with a simultaneous byte while entry 4 high byte is pending
        for (int i = 0; i < 4; i++) load_entry(16'(100 + i));
        send_byte(8'h11);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        rd_chk("rs_rd4_kept", 4, 204);
        rd_chk("rs_rd1_new", 1, 101);
        load_entry(16'h0122);
        rd_chk("rs_rd0", 0, 290);
        rd_chk("rs_rd2_kept", 2, 102);
        rd_chk("rs_rd3_kept", 3, 103);
        rd_chk("rs_rd4_still", 4, 204);

        // Reset mid-load after 7 entries
        for (int i = 1; i < 7; i++) load_entry(16'(50 + i));
        rd_chk("mr_rd6", 6, 56);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) rd_chk($sformatf("mr_rd%0d", i), i, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mr_no_done", 32'(done_cnt - d0), 0);
        chk("mr_busy_after", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_loader.md
Name: branch_target_loader

Overview:
- Writer end of the branch-target lookup path.
- Accepts a byte stream from the boot/test loader over a valid/ready handshake and assembles 10-bit branch targets, two bytes per entry.
- Writes the targets into a 16-entry table and serves the same combinational index-to-target read that the fetch stage uses for branch redirects.
- Makes the branch-target table reprogrammable at runtime instead of fixed at elaboration.

Parameters:
- D, 10, target PC width in bits; legal range 9..16.
- N, 16, number of table entries; the read index is 4 bits, so N must be at most 16.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins or restarts a table load at entry 0.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- rd_addr  input  4  branch index from decode.
- rd_target  output  D  target PC for rd_addr.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse after the last entry is written.
- fmt_err  output  1  sticky flag: a high byte carried nonzero unused bits.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, entry counter=0, lo_hold=0.
  - in_ready=0, busy=0, done=0, fmt_err=0.
  - All N table entries are cleared to 0, so rd_target=0 for every index.
- A byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_data and in_valid have no other effect.
- FSM states: IDLE, LOAD_LO, LOAD_HI.
  - IDLE: in_ready=0, busy=0. start -> LOAD_LO, counter=0, fmt_err cleared.
  - LOAD_LO: in_ready=1, busy=1. On an accepted byte, lo_hold<=in_data, then -> LOAD_HI.
  - LOAD_HI: in_ready=1, busy=1. On an accepted byte:
    - table[counter] <= {in_data[D-9:0], lo_hold}.
    - If in_data[7:D-8] != 0 (only when D<16), fmt_err <= 1. The entry is still written with the truncated value.
    - If counter==N-1: -> IDLE, and done=1 in the following cycle.
    - Otherwise: counter+1, -> LOAD_LO.
- Stalls: in_valid=0 holds the current state indefinitely; there is no timeout.
- Restart: start in LOAD_LO or LOAD_HI returns to LOAD_LO with counter=0.
  - A held low byte is discarded.
  - Entries already written keep their new values until they are overwritten.
  - start has priority over a byte accepted in the same cycle; that byte is dropped.
- start in the same cycle that done is high begins a new load normally.
- Read port:
  - rd_target = table[rd_addr], purely combinational, 0-cycle latency.
  - rd_addr >= N returns 0.
  - A read of the entry being written in the same cycle returns the old value; the new value is visible after the edge.
  - Reads are legal at any time. During a load they return a mix of new and old entries. Software must wait for done before branching.
- Width rules:
  - The low byte supplies target[7:0].
  - The high byte supplies target[D-1:8].
  - Counter width is ceil(log2 N), with no wrap beyond N-1.
- Asserting reset mid-load aborts the load and clears the table. No done pulse is produced.

Test Plan:
- Reset, then read every index -> rd_target=0 for all 16; in_ready=0, busy=0, done=0.
- start, then stream bytes 0x00,0x00, 0x0A,0x00, 0x2D,0x00, 0x67,0x00 … 32 bytes for targets 0,10,45,103,76,91,84,101,1,18,0… -> done pulses once, 1 cycle after the 32nd byte. Then rd_addr=3 -> 103 and rd_addr=9 -> 18, with fmt_err=0.
- Handshake stall: drop in_valid for 5 cycles between the low and high byte of entry 2, target 0x3FF (bytes 0xFF,0x03) -> state holds in LOAD_HI. Once the stream resumes and the load completes, rd_addr=2 -> 1023.
- High byte 0xFC with low byte 0x05 for entry 0 -> table[0]=0x005 and fmt_err=1. fmt_err stays 1 through done and clears on the next start.
- start asserted while LOAD_HI of entry 4 is pending, with a byte in the same cycle -> that byte is dropped and the next byte is taken as entry 0's low byte. Entries 0-3 hold their new values until rewritten.
- reset_n pulsed low for 1 cycle mid-load after 7 entries -> busy=0 immediately, all reads 0, no done pulse.
